stopwatch_ctrl: RTL

Control and sequencing block for the stopwatch timer datapath on the 7-segment board. Conditions the raw PAUSE/RST buttons and the SEL/ADJ switches, and divides the master clock into 1 Hz count and 2 Hz adjust enables. A mode FSM turns these into single-cycle command pulses (count, adjust-seconds, adjust-minutes, clear) for the minutes/seconds counter block. Also produces the adjust-mode blink phase for the display driver.

---
 rtl/stopwatch_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: conditions the raw buttons and switches, divides the master
// clock into the 1 Hz count and 2 Hz adjust enables, and runs the mode FSM
// that issues single-cycle commands to the minutes/seconds counter block.
// Also produces the adjust-mode blink phase for the display driver.
module stopwatch_ctrl #(
  parameter int DIV_1HZ   = 100_000_000,
  parameter int DIV_2HZ   = 50_000_000,
  parameter int DIV_BLINK = 25_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       BTN_PAUSE,
  input  logic       BTN_RST,
  input  logic       SW_SEL,
  input  logic       SW_ADJ,
  output logic       CNT_EN,
  output logic       SEC_INC,
  output logic       MIN_INC,
  output logic       CLR,
  output logic       BLINK,
  output logic       PAUSED,
  output logic [1:0] STATE
);

  localparam int W1 = (DIV_1HZ   > 1) ? $clog2(DIV_1HZ)   : 1;
  localparam int W2 = (DIV_2HZ   > 1) ? $clog2(DIV_2HZ)   : 1;
  localparam int WB = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;
  localparam int WD = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [W1-1:0] D1_MAX = W1'(DIV_1HZ - 1);
  localparam logic [W1-1:0] D1_ONE = W1'(1);
  localparam logic [W2-1:0] D2_MAX = W2'(DIV_2HZ - 1);
  localparam logic [W2-1:0] D2_ONE = W2'(1);
  localparam logic [WB-1:0] BL_MAX = WB'(DIV_BLINK - 1);
  localparam logic [WB-1:0] BL_ONE = WB'(1);
  localparam logic [WD-1:0] DB_MAX = WD'(DB_CYCLES - 1);
  localparam logic [WD-1:0] DB_ONE = WD'(1);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_PAUSE   = 2'b01,
    S_ADJ_SEC = 2'b10,
    S_ADJ_MIN = 2'b11
  } state_t;

  // Input bit order: 0 pause button, 1 clear button, 2 select switch, 3 adjust switch
  logic [3:0]    raw;
  logic [3:0]    sync_p0;
  logic [3:0]    sync_p1;
  logic [3:0]    level;
  logic [WD-1:0] db_cnt [4];
  logic [1:0]    btn_p2;

  logic          pause_ev;
  logic          clr_ev;
  logic          sel;
  logic          adj;

  logic [W1-1:0] d1;
  logic [W1-1:0] d1_next;
  logic [W2-1:0] d2;
  logic [W2-1:0] d2_next;
  logic [WB-1:0] bdiv;
  logic          blink_ph;
  logic          ph_next;

  state_t        state;
  state_t        state_next;
  logic          flag;
  logic          flag_next;

  logic          in_adj;
  logic          next_adj;
  logic          d1_wrap;
  logic          d2_wrap;
  logic          cnt_next;
  logic          sec_next;
  logic          min_next;
  logic          blink_next;

  assign raw      = {SW_ADJ, SW_SEL, BTN_RST, BTN_PAUSE};
  assign sel      = level[2];
  assign adj      = level[3];
  assign pause_ev = level[0] & ~btn_p2[0];
  assign clr_ev   = level[1] & ~btn_p2[1];
  assign ph_next  = blink_ph ^ (bdiv == BL_MAX);

  // Two-flop synchronizer, then per-input debounce: a level is accepted only
  // after it has differed from the debounced value for DB_CYCLES edges in a row.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      level   <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          level[i]  <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Delayed button levels for rising-edge event detection.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_p2 <= '0;
    end else begin
      btn_p2 <= level[1:0];
    end
  end

  // Free-running blink divider; the phase flips on every wrap.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      bdiv     <= '0;
      blink_ph <= 1'b0;
    end else begin
      bdiv     <= (bdiv == BL_MAX) ? '0 : bdiv + BL_ONE;
      blink_ph <= ph_next;
    end
  end

  // Mode FSM next state, pause flag, divider updates and next command outputs.
  always_comb begin
    in_adj     = (state == S_ADJ_SEC) || (state == S_ADJ_MIN);
    flag_next  = flag;
    state_next = state;
    d1_wrap    = 1'b0;
    d2_wrap    = 1'b0;
    d1_next    = '0;
    d2_next    = '0;
    cnt_next   = 1'b0;
    sec_next   = 1'b0;
    min_next   = 1'b0;
    next_adj   = 1'b0;
    blink_next = 1'b0;

    if (pause_ev && !in_adj) begin
      flag_next = ~flag;
    end

    // Adjust switch dominates; leaving adjust restores the paused/running mode.
    if (adj) begin
      state_next = sel ? S_ADJ_MIN : S_ADJ_SEC;
    end else if (in_adj) begin
      state_next = flag ? S_PAUSE : S_RUN;
    end else begin
      state_next = flag_next ? S_PAUSE : S_RUN;
    end

    d1_wrap = (state == S_RUN) && (d1 == D1_MAX);
    d2_wrap = in_adj && (d2 == D2_MAX);

    // d1 only runs in RUN so that resuming always restarts a full second.
    if ((state != S_RUN) || clr_ev || d1_wrap) begin
      d1_next = '0;
    end else begin
      d1_next = d1 + D1_ONE;
    end

    // d2 restarts on any mode change so each adjust field gets a full period.
    if (!in_adj || clr_ev || (state_next != state) || d2_wrap) begin
      d2_next = '0;
    end else begin
      d2_next = d2 + D2_ONE;
    end

    // Clear wins over every count command in its cycle.
    cnt_next   = d1_wrap && !clr_ev;
    sec_next   = d2_wrap && (state == S_ADJ_SEC) && !clr_ev;
    min_next   = d2_wrap && (state == S_ADJ_MIN) && !clr_ev;
    next_adj   = (state_next == S_ADJ_SEC) || (state_next == S_ADJ_MIN);
    blink_next = next_adj && ph_next;
  end

  // State register, pause flag and enable dividers.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_RUN;
      flag  <= 1'b0;
      d1    <= '0;
      d2    <= '0;
    end else begin
      state <= state_next;
      flag  <= flag_next;
      d1    <= d1_next;
      d2    <= d2_next;
    end
  end

  // Registered command and status outputs; reset drops any pulse at once.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      CNT_EN  <= 1'b0;
      SEC_INC <= 1'b0;
      MIN_INC <= 1'b0;
      CLR     <= 1'b0;
      BLINK   <= 1'b0;
    end else begin
      CNT_EN  <= cnt_next;
      SEC_INC <= sec_next;
      MIN_INC <= min_next;
      CLR     <= clr_ev;
      BLINK   <= blink_next;
    end
  end

  assign STATE  = state;
  assign PAUSED = flag;

endmodule
